// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    inst_t       inst;
    logic        fault;
    logic [63:0] addr;
  } imem_resp_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port, one asynchronous read port.
// The read value is captured by the caller at the same edge as a write, which gives read-before-write.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  inst_t         wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output inst_t         rd_data_o
);

  inst_t mem_q [DEPTH];

  // Contents are deliberately left unreset so the program survives rst.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: fault check, LATENCY-deep response pipeline, optional access counter.
// Define IMEM_ACCESS_CNT_EN to add the 64-bit acc_cnt output.
module inst_mem_resp
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              inst_addr,
  input  logic                     inst_ena,
  output inst_t                    inst,
  output logic                     inst_valid,
  output logic                     inst_fault,
  output logic [63:0]              resp_addr,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  inst_t                    ld_data
`ifdef IMEM_ACCESS_CNT_EN
  ,
  output logic [63:0]              acc_cnt
`endif
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd4;

  logic [63:0]        off;
  logic               misaligned;
  logic               out_of_range;
  logic               fault;
  logic [AW-1:0]      rd_idx;
  inst_t              rd_data;
  imem_resp_t         stage_d;
  imem_resp_t         pipe_q [LATENCY];
  logic [LATENCY-1:0] vld_q;

  assign off          = inst_addr - BASE_ADDR;
  assign misaligned   = |inst_addr[1:0];
  // Comparing the raw address as well as the offset stops a below-base address wrapping into range.
  assign out_of_range = (inst_addr < BASE_ADDR) || (off >= SPAN);
  assign fault        = misaligned || out_of_range;
  assign rd_idx       = off[AW+1:2];

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .we_i      (ld_we),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .rd_addr_i (rd_idx),
    .rd_data_o (rd_data)
  );

  always_comb begin
    stage_d       = '0;
    stage_d.inst  = fault ? NOP_INST : rd_data;
    stage_d.fault = fault;
    stage_d.addr  = inst_addr;
  end

  // Payload stages only load when their input is valid, so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= inst_ena;
      if (inst_ena) begin
        pipe_q[0] <= stage_d;
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end
  end

  assign inst       = pipe_q[LATENCY-1].inst;
  assign inst_fault = pipe_q[LATENCY-1].fault;
  assign resp_addr  = pipe_q[LATENCY-1].addr;
  assign inst_valid = vld_q[LATENCY-1];

`ifdef IMEM_ACCESS_CNT_EN
  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  assign cnt_d = inst_ena ? cnt_q + 64'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign acc_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp (DEPTH=16, LATENCY=2, BASE_ADDR=0); directed vectors.
module tb_inst_mem_resp;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inst_addr = '0;
  logic        inst_ena = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_fault;
  logic [63:0] resp_addr;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
`ifdef IMEM_ACCESS_CNT_EN
  logic [63:0] acc_cnt;
`endif

  inst_mem_resp #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (64'h0),
    .LATENCY   (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_addr  (inst_addr),
    .inst_ena   (inst_ena),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_fault (inst_fault),
    .resp_addr  (resp_addr),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
`ifdef IMEM_ACCESS_CNT_EN
    ,
    .acc_cnt    (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] inst;
    logic        fault;
    logic [63:0] addr;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_exp  = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, log the expected response if accepted, then advance past the edge.
  task automatic issue(input logic ena, input logic [63:0] a, input logic [31:0] e_inst,
                       input logic e_fault, input logic we, input logic [3:0] la,
                       input logic [31:0] ld);
    exp_t e;
    inst_ena  = ena;
    inst_addr = a;
    ld_we     = we;
    ld_addr   = la;
    ld_data   = ld;
    if (ena && !rst) begin
      e.inst  = e_inst;
      e.fault = e_fault;
      e.addr  = a;
      e.due   = edge_cnt + LAT;
      q.push_back(e);
      acc_exp++;
    end
    @(posedge clk);
    #1;
    inst_ena = 1'b0;
    ld_we    = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a, input logic [31:0] e_inst, input logic e_fault);
    issue(1'b1, a, e_inst, e_fault, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic idle();
    issue(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic load(input logic [3:0] la, input logic [31:0] d);
    issue(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, la, d);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (inst_valid) begin
          n_checks++;
          if (q.size() == 0) begin
            $display("FAIL resp_unexpected: got valid addr %h at edge %0d, required no response", resp_addr, edge_cnt);
          end else begin
            exp_t e;
            e = q.pop_front();
            if (inst === e.inst && inst_fault === e.fault && resp_addr === e.addr && edge_cnt == e.due)
              n_pass++;
            else
              $display("FAIL resp: got inst=%h fault=%b addr=%h edge=%0d, required inst=%h fault=%b addr=%h edge=%0d",
                       inst, inst_fault, resp_addr, edge_cnt, e.inst, e.fault, e.addr, e.due);
          end
        end else if (q.size() > 0 && q[0].due <= edge_cnt) begin
          exp_t e;
          e = q.pop_front();
          n_checks++;
          $display("FAIL resp_missing: got no valid at edge %0d, required inst=%h addr=%h", edge_cnt, e.inst, e.addr);
        end
      end
    join_none

    @(posedge clk);
    #1;
    // Program load while held in reset.
    load(4'd0, 32'h11);
    load(4'd1, 32'h22);
    load(4'd2, 32'h33);
    load(4'd3, 32'h44);
    load(4'd5, 32'hAAAA);
    load(4'd15, 32'hF00D_F00F);
    @(negedge clk);
    check_eq("rst_valid", {63'd0, inst_valid}, 64'd0);
    check_eq("rst_inst", {32'd0, inst}, 64'd0);
    check_eq("rst_fault", {63'd0, inst_fault}, 64'd0);
    check_eq("rst_addr", resp_addr, 64'd0);
`ifdef IMEM_ACCESS_CNT_EN
    check_eq("rst_acc_cnt", acc_cnt, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_exp = 0;

    // Sequential fetch
    fetch(64'h0, 32'h11, 1'b0);
    fetch(64'h4, 32'h22, 1'b0);
    fetch(64'h8, 32'h33, 1'b0);
    fetch(64'hC, 32'h44, 1'b0);
    // Bubble between requests
    fetch(64'h4, 32'h22, 1'b0);
    idle();
    fetch(64'h8, 32'h33, 1'b0);
    // Faults and the last in-range word
    fetch(64'h2, NOP, 1'b1);
    fetch(64'h40, NOP, 1'b1);
    fetch(64'h3C, 32'hF00D_F00F, 1'b0);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, NOP, 1'b1);
    fetch(64'h7, NOP, 1'b1);
    // Read-before-write on word 5
    issue(1'b1, 64'h14, 32'hAAAA, 1'b0, 1'b1, 4'd5, 32'hBBBB);
    fetch(64'h14, 32'hBBBB, 1'b0);
    idle();
    idle();
    idle();

    // Reset with a request in flight and one presented during reset: neither responds.
    fetch(64'h8, 32'h33, 1'b0);
    q.delete();
    rst = 1'b1;
    inst_ena = 1'b1;
    inst_addr = 64'hC;
    @(posedge clk);
    #1;
    inst_ena = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", {63'd0, inst_valid}, 64'd0);
`ifdef IMEM_ACCESS_CNT_EN
    check_eq("midrst_acc_cnt", acc_cnt, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_exp = 0;
    idle();
    idle();
    idle();

    // Ten requests (two faulting) with three idle cycles mixed in.
    fetch(64'h0, 32'h11, 1'b0);
    fetch(64'h4, 32'h22, 1'b0);
    idle();
    fetch(64'h8, 32'h33, 1'b0);
    fetch(64'hC, 32'h44, 1'b0);
    idle();
    fetch(64'h3C, 32'hF00D_F00F, 1'b0);
    fetch(64'h2, NOP, 1'b1);
    fetch(64'h14, 32'hBBBB, 1'b0);
    idle();
    fetch(64'h40, NOP, 1'b1);
    fetch(64'h0, 32'h11, 1'b0);
    fetch(64'h4, 32'h22, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) idle();
    check_eq("drain_pending", 64'(q.size()), 64'd0);
`ifdef IMEM_ACCESS_CNT_EN
    check_eq("acc_cnt", acc_cnt, 64'(acc_exp));
    check_eq("acc_cnt_ten", acc_cnt, 64'd10);
`endif
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
